zapper_hit_sequencer: RTL and testbench

ZAPPER_HIT_SEQUENCER -- requirements
Module: zapper_hit_sequencer

---
 rtl/zapper_hit_sequencer.sv | 140 ++++++++++++++
 tb/tb_zapper_hit_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/zapper_hit_sequencer.sv
// Light-gun hit sequencer: blacks the screen, flashes each live duck's box white on
// successive frames, and reports which duck (if any) the photodiode saw.
module zapper_hit_sequencer #(
  parameter int BULLETS       = 3,
  parameter int SETTLE_CYCLES = 1000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_start,
  input  logic       trigger,
  input  logic       is_light,
  input  logic [1:0] duck_alive,
  input  logic       reload,
  output logic       mask_black,
  output logic [1:0] target_sel,
  output logic [1:0] hit,
  output logic       miss,
  output logic       busy,
  output logic [2:0] bullet_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_BLACK,
    S_TGT0,
    S_TGT1,
    S_RESULT
  } state_t;

  localparam logic [2:0]  FULL_MAG = 3'(BULLETS);
  localparam logic [15:0] SETTLE   = 16'(SETTLE_CYCLES);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_trig_q;
  logic        r_light_seen;
  logic        r_hit0;
  logic        r_hit1;
  logic [15:0] r_settle;
  logic        w_fire;
  logic        w_hit0_nxt;
  logic        w_hit1_nxt;
  logic        w_enter_clear;
  logic        w_light_ok;

  assign w_light_ok = is_light && (r_settle >= SETTLE);

  always_comb begin
    w_state_nxt = r_state;
    w_hit0_nxt  = r_hit0;
    w_hit1_nxt  = r_hit1;
    w_fire      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (trigger && !r_trig_q && (bullet_count != 3'd0)) begin
          w_fire      = 1'b1;
          w_state_nxt = S_ARM;
        end
      end
      S_ARM: begin
        if (frame_start) w_state_nxt = S_BLACK;
      end
      S_BLACK: begin
        // Light on an all-black frame means the gun sees a lamp, not a duck.
        if (frame_start) begin
          if (r_light_seen)       w_state_nxt = S_RESULT;
          else if (duck_alive[0]) w_state_nxt = S_TGT0;
          else if (duck_alive[1]) w_state_nxt = S_TGT1;
          else                    w_state_nxt = S_RESULT;
        end
      end
      S_TGT0: begin
        if (frame_start) begin
          w_hit0_nxt  = r_light_seen;
          w_state_nxt = duck_alive[1] ? S_TGT1 : S_RESULT;
        end
      end
      S_TGT1: begin
        if (frame_start) begin
          w_hit1_nxt  = r_light_seen;
          w_state_nxt = S_RESULT;
        end
      end
      S_RESULT: begin
        w_state_nxt = S_IDLE;
        w_hit0_nxt  = 1'b0;
        w_hit1_nxt  = 1'b0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_enter_clear = (w_state_nxt != r_state) &&
                         (w_state_nxt inside {S_BLACK, S_TGT0, S_TGT1});

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_trig_q     <= 1'b1;
      r_light_seen <= 1'b0;
      r_hit0       <= 1'b0;
      r_hit1       <= 1'b0;
      r_settle     <= 16'd0;
      bullet_count <= FULL_MAG;
      mask_black   <= 1'b0;
      target_sel   <= 2'b00;
      hit          <= 2'b00;
      miss         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_trig_q <= trigger;
      r_hit0   <= w_hit0_nxt;
      r_hit1   <= w_hit1_nxt;

      if (frame_start)              r_settle <= 16'd0;
      else if (r_settle != 16'hFFFF) r_settle <= r_settle + 16'd1;

      if (w_enter_clear)   r_light_seen <= 1'b0;
      else if (w_light_ok) r_light_seen <= 1'b1;

      if (reload)      bullet_count <= FULL_MAG;
      else if (w_fire) bullet_count <= bullet_count - 3'd1;

      mask_black <= (w_state_nxt inside {S_BLACK, S_TGT0, S_TGT1});
      target_sel <= {w_state_nxt == S_TGT1, w_state_nxt == S_TGT0};
      busy       <= (w_state_nxt != S_IDLE);
      if (w_state_nxt == S_RESULT) begin
        hit  <= {w_hit1_nxt, w_hit0_nxt};
        miss <= !w_hit1_nxt && !w_hit0_nxt;
      end else begin
        hit  <= 2'b00;
        miss <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_zapper_hit_sequencer.sv
// Scoreboard bench for zapper_hit_sequencer: shots are described per frame
// (ARM, BLACK, first target, second target) and the result is predicted from that.
module tb_zapper_hit_sequencer;
  localparam int BUL   = 3;
  localparam int SET   = 20;
  localparam int FRAME = 60;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_start;
  logic       trigger;
  logic       is_light;
  logic [1:0] duck_alive;
  logic       reload;
  logic       mask_black;
  logic [1:0] target_sel;
  logic [1:0] hit;
  logic       miss;
  logic       busy;
  logic [2:0] bullet_count;

  always #10 Clk = ~Clk;

  zapper_hit_sequencer #(.BULLETS(BUL), .SETTLE_CYCLES(SET)) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .trigger(trigger),
    .is_light(is_light), .duck_alive(duck_alive), .reload(reload),
    .mask_black(mask_black), .target_sel(target_sel), .hit(hit), .miss(miss),
    .busy(busy), .bullet_count(bullet_count)
  );

  int         tests = 0;
  int         fails = 0;
  logic [2:0] exp_q[$];
  int         off = 0;
  int         frame_no = 0;
  bit         shot_on = 0;
  int         base = 0;
  int         plan[4];
  int         late_off[4];
  int         mask_cyc = 0;
  int         tsel_seq = 0;
  logic [1:0] last_tsel = 2'b00;
  int         cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  // Frame timing and photodiode: offset 0 is the frame_start cycle.
  always @(negedge Clk) begin
    int rel;
    off = (off == FRAME - 1) ? 0 : off + 1;
    frame_start = (off == 0);
    if (off == 0) frame_no++;
    is_light = 1'b0;
    if (shot_on) begin
      rel = frame_no - base;
      if (rel >= 0 && rel <= 3) begin
        if (plan[rel] == 1) is_light = (off >= 1) && (off <= SET);
        else if (plan[rel] == 2) is_light = (off == late_off[rel]);
      end
    end
  end

  always @(negedge Clk) begin
    logic [2:0] e;
    if (mask_black) mask_cyc++;
    if (target_sel != last_tsel && target_sel != 2'b00) tsel_seq = tsel_seq * 4 + int'(target_sel);
    last_tsel = target_sel;
    if (hit != 2'b00 || miss) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: hit=%b miss=%b with nothing pending", hit, miss);
      end else begin
        e = exp_q.pop_front();
        check("hit_miss", {hit, miss}, e);
      end
    end
  end

  task automatic wait_trig_window();
    int t;
    int guard;
    t = $urandom_range(5, FRAME - 10);
    guard = 0;
    do begin
      tick();
      guard++;
    end while (off != t && guard < 3 * FRAME);
  endtask

  task automatic do_shot(input logic [1:0] alive, input int p0, input int p1,
                         input int p2, input int p3, input bit rl);
    int   ducks[$];
    logic [1:0] h;
    bit   lamp, fired;
    int   seq, frames, m0, guard, hold;
    wait_trig_window();
    plan = '{p0, p1, p2, p3};
    for (int i = 0; i < 4; i++) late_off[i] = $urandom_range(SET + 1, FRAME - 2);
    duck_alive = alive;
    base = frame_no;
    shot_on = 1;
    trigger = 1'b1;
    reload = rl;
    m0 = mask_cyc;
    tsel_seq = 0;
    fired = (cnt > 0);
    if (rl) cnt = BUL;
    else if (fired) cnt--;
    lamp = (p1 == 2);
    h = 2'b00;
    seq = 0;
    for (int d = 0; d < 2; d++) if (alive[d]) ducks.push_back(d);
    if (!lamp) begin
      for (int i = 0; i < ducks.size(); i++) begin
        if (plan[2 + i] == 2) h[ducks[i]] = 1'b1;
        seq = seq * 4 + (1 << ducks[i]);
      end
    end
    frames = lamp ? 1 : 1 + ducks.size();
    if (fired) exp_q.push_back({h, h == 2'b00});
    tick();
    reload = 1'b0;
    check("bullet_after_trigger", bullet_count, cnt);
    check("busy_after_trigger", busy, fired);
    hold = $urandom_range(0, 3);
    for (int i = 0; i < hold; i++) tick();
    trigger = 1'b0;
    if (fired) begin
      guard = 0;
      while (busy && guard < 6 * FRAME) begin
        tick();
        guard++;
      end
      check("shot_completes", busy, 0);
      check("mask_black_cycles", mask_cyc - m0, frames * FRAME);
      check("target_sel_order", tsel_seq, seq);
      check("result_reported", exp_q.size(), 0);
    end else begin
      for (int i = 0; i < 3; i++) tick();
      check("empty_mag_ignored", busy, 0);
      check("empty_mag_count", bullet_count, 0);
    end
    shot_on = 0;
  endtask

  initial begin
    #(20 * 100000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int guard;
    Reset = 1'b1;
    trigger = 1'b1;
    reload = 1'b0;
    duck_alive = 2'b00;
    frame_start = 1'b0;
    is_light = 1'b0;
    for (int i = 0; i < 4; i++) begin plan[i] = 0; late_off[i] = 0; end
    repeat (4) tick();
    check("rst_mask", mask_black, 0);
    check("rst_tsel", target_sel, 0);
    check("rst_hit", hit, 0);
    check("rst_miss", miss, 0);
    check("rst_busy", busy, 0);
    check("rst_bullets", bullet_count, BUL);
    Reset = 1'b0;
    repeat (3) tick();
    check("held_trigger_no_fire", busy, 0);
    trigger = 1'b0;
    tick();
    cnt = BUL;

    do_shot(2'b01, 0, 0, 2, 0, 0);
    do_shot(2'b11, 0, 0, 0, 2, 0);
    do_shot(2'b11, 0, 2, 2, 2, 0);
    do_shot(2'b01, 0, 0, 2, 0, 0);
    reload = 1'b1;
    tick();
    reload = 1'b0;
    cnt = BUL;
    check("reload_refill", bullet_count, BUL);
    do_shot(2'b01, 0, 0, 1, 0, 0);
    do_shot(2'b10, 2, 0, 2, 0, 0);
    do_shot(2'b00, 0, 0, 0, 0, 1);

    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        reload = 1'b1;
        tick();
        reload = 1'b0;
        cnt = BUL;
        check("reload_between", bullet_count, BUL);
      end
      do_shot(2'($urandom_range(0, 3)), $urandom_range(0, 2), $urandom_range(0, 2),
              $urandom_range(0, 2), $urandom_range(0, 2), ($urandom_range(0, 5) == 0));
    end

    // Abort a shot in TGT0 that would otherwise score a hit.
    if (cnt == 0) begin
      reload = 1'b1;
      tick();
      reload = 1'b0;
    end
    wait_trig_window();
    plan = '{0, 0, 2, 0};
    late_off[2] = SET + 2;
    duck_alive = 2'b01;
    base = frame_no;
    shot_on = 1;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    guard = 0;
    while (target_sel != 2'b01 && guard < 4 * FRAME) begin
      tick();
      guard++;
    end
    check("reached_tgt0", target_sel, 2'b01);
    repeat (SET + 10) tick();
    Reset = 1'b1;
    #1;
    check("abort_mask", mask_black, 0);
    check("abort_tsel", target_sel, 0);
    check("abort_hit", hit, 0);
    check("abort_miss", miss, 0);
    check("abort_busy", busy, 0);
    check("abort_bullets", bullet_count, BUL);
    repeat (2) tick();
    Reset = 1'b0;
    shot_on = 0;
    repeat (4 * FRAME) tick();
    check("post_abort_idle", busy, 0);
    check("post_abort_bullets", bullet_count, BUL);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
